// File: rtl/mem_loader_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the stream-to-memory loader.
package mem_loader_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  localparam int unsigned LEN_BYTES = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_WDATA,
    ST_WCOMMIT,
    ST_RREQ,
    ST_RWAIT,
    ST_RSEND,
    ST_ACK
  } state_t;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int unsigned bytes_for(input int unsigned bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/memory_bus.sv
// Word-addressed memory port: client drives addr/w_data/we, memory returns r_data one cycle later.
interface memory_bus #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  we;
  logic [DATA_WIDTH-1:0] r_data;

  modport client (output addr, output w_data, output we, input r_data);
  modport mem    (input addr, input w_data, input we, output r_data);
endinterface

// File: rtl/word_byte_serializer.sv
// Emits a loaded word as little-endian bytes over a valid/ready port; a count of 1 sends a single byte.
module word_byte_serializer #(
  parameter int unsigned WORD_BYTES = 2,
  localparam int unsigned CNT_W = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [WORD_BYTES*8-1:0] load_data,
  input  logic [CNT_W-1:0]        load_count,
  input  logic                    m_ready,
  output logic [7:0]              m_data,
  output logic                    m_valid,
  output logic                    done_c
);

  logic [WORD_BYTES*8-1:0] sr;
  logic [WORD_BYTES*8-1:0] sr_next;
  logic [CNT_W-1:0]        left;

  assign sr_next = sr >> 8;
  assign done_c  = m_valid && m_ready && (left == CNT_W'(1));

  // m_data only moves on a handshake or a fresh load, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      left    <= '0;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
    end else if (load) begin
      sr      <= load_data;
      left    <= load_count;
      m_valid <= (load_count != '0);
      m_data  <= load_data[7:0];
    end else if (m_valid && m_ready) begin
      if (done_c) begin
        m_valid <= 1'b0;
      end else begin
        sr     <= sr_next;
        m_data <= sr_next[7:0];
        left   <= left - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_stream_loader.sv
// Byte-stream command front-end that bursts words into, or dumps words out of, a memory_bus.
module mem_stream_loader
  import mem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       err,
  memory_bus.client  bus
);

  localparam int unsigned ADDR_BYTES = bytes_for(ADDR_WIDTH);
  localparam int unsigned WORD_BYTES = bytes_for(DATA_WIDTH);
  localparam int unsigned AB_W       = ADDR_BYTES * 8;
  localparam int unsigned WB_W       = WORD_BYTES * 8;
  localparam int unsigned LB_W       = LEN_BYTES * 8;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SER_CW     = $clog2(WORD_BYTES + 1);

  state_t state, next_state;

  logic [AB_W-1:0]       addr_sr;
  logic [LB_W-1:0]       len_sr;
  logic [WB_W-1:0]       wd_sr;
  logic [CNT_W-1:0]      byte_cnt;
  logic [LB_W-1:0]       remaining;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  we_q;
  logic                  is_read;

  logic              accept_c;
  logic              field_last_c;
  logic              last_word_c;
  logic              op_ok_c;
  logic [AB_W-1:0]   addr_shift_c;
  logic [LB_W-1:0]   len_shift_c;
  logic [WB_W-1:0]   wd_shift_c;
  logic              ser_load_c;
  logic [WB_W-1:0]   ser_data_c;
  logic [SER_CW-1:0] ser_count_c;
  logic              ser_done_c;

  assign bus.addr   = addr_q;
  assign bus.w_data = w_data_q;
  assign bus.we     = we_q;

  assign accept_c    = s_valid && s_ready;
  assign last_word_c = (remaining == LB_W'(1));
  assign op_ok_c     = (s_data == OP_WRITE) || (s_data == OP_READ);

  // Little-endian field assembly: each new byte enters at the top and earlier bytes slide down.
  always_comb begin
    addr_shift_c = (addr_sr >> 8) | (AB_W'(s_data) << ((ADDR_BYTES - 1) * 8));
    len_shift_c  = (len_sr >> 8)  | (LB_W'(s_data) << ((LEN_BYTES - 1) * 8));
    wd_shift_c   = (wd_sr >> 8)   | (WB_W'(s_data) << ((WORD_BYTES - 1) * 8));
    case (state)
      ST_ADDR:  field_last_c = (byte_cnt == CNT_W'(ADDR_BYTES - 1));
      ST_LEN:   field_last_c = (byte_cnt == CNT_W'(LEN_BYTES - 1));
      ST_WDATA: field_last_c = (byte_cnt == CNT_W'(WORD_BYTES - 1));
      default:  field_last_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state plus serializer load: read words on RWAIT, the ack byte on entry to ACK.
  always_comb begin
    next_state  = state;
    ser_load_c  = 1'b0;
    ser_data_c  = WB_W'(ACK_BYTE);
    ser_count_c = SER_CW'(1);
    case (state)
      ST_IDLE:    if (accept_c && op_ok_c) next_state = ST_ADDR;
      ST_ADDR:    if (accept_c && field_last_c) next_state = ST_LEN;
      ST_LEN: begin
        if (accept_c && field_last_c) begin
          if (len_shift_c == '0) next_state = ST_ACK;
          else if (is_read)      next_state = ST_RREQ;
          else                   next_state = ST_WDATA;
        end
      end
      ST_WDATA:   if (accept_c && field_last_c) next_state = ST_WCOMMIT;
      ST_WCOMMIT: next_state = last_word_c ? ST_ACK : ST_WDATA;
      ST_RREQ:    next_state = ST_RWAIT;
      ST_RWAIT:   next_state = ST_RSEND;
      ST_RSEND:   if (ser_done_c) next_state = last_word_c ? ST_ACK : ST_RREQ;
      ST_ACK:     if (ser_done_c) next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
    if (state == ST_RWAIT) begin
      ser_load_c  = 1'b1;
      ser_data_c  = WB_W'(bus.r_data);
      ser_count_c = SER_CW'(WORD_BYTES);
    end else if (next_state == ST_ACK && state != ST_ACK) begin
      ser_load_c = 1'b1;
    end
  end

  // Status flags are decoded from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      w_data_q  <= '0;
      addr_sr   <= '0;
      len_sr    <= '0;
      wd_sr     <= '0;
      byte_cnt  <= '0;
      remaining <= '0;
      is_read   <= 1'b0;
    end else begin
      s_ready <= (next_state == ST_IDLE) || (next_state == ST_ADDR) ||
                 (next_state == ST_LEN)  || (next_state == ST_WDATA);
      busy    <= (next_state != ST_IDLE);
      we_q    <= (next_state == ST_WCOMMIT);
      err     <= (state == ST_IDLE) && accept_c && !op_ok_c;
      if (accept_c && state != ST_IDLE)
        byte_cnt <= field_last_c ? '0 : byte_cnt + CNT_W'(1);
      case (state)
        ST_IDLE: if (accept_c) is_read <= (s_data == OP_READ);
        ST_ADDR: if (accept_c) begin
          addr_sr <= addr_shift_c;
          if (field_last_c) addr_q <= ADDR_WIDTH'(addr_shift_c);
        end
        ST_LEN: if (accept_c) begin
          len_sr <= len_shift_c;
          if (field_last_c) remaining <= len_shift_c;
        end
        ST_WDATA: if (accept_c) begin
          wd_sr <= wd_shift_c;
          if (field_last_c) w_data_q <= DATA_WIDTH'(wd_shift_c);
        end
        ST_WCOMMIT: begin
          addr_q    <= addr_q + ADDR_WIDTH'(1);
          remaining <= remaining - LB_W'(1);
        end
        ST_RSEND: if (ser_done_c) begin
          addr_q    <= addr_q + ADDR_WIDTH'(1);
          remaining <= remaining - LB_W'(1);
        end
        default: ;
      endcase
    end
  end

  word_byte_serializer #(.WORD_BYTES(WORD_BYTES)) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ser_load_c),
    .load_data  (ser_data_c),
    .load_count (ser_count_c),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .done_c     (ser_done_c)
  );

endmodule

// File: tb/tb_mem_stream_loader.sv
// Directed bench for mem_stream_loader with a behavioural 1-cycle-read memory and a write monitor.
module tb_mem_stream_loader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_bus #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  mem_stream_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .err     (err),
    .bus     (bus_if)
  );

  logic [DW-1:0] mem [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    bus_if.r_data = '0;
  end

  always @(posedge clk) begin
    if (bus_if.we) mem[bus_if.addr] <= bus_if.w_data;
    bus_if.r_data <= mem[bus_if.addr];
  end

  // Monitor: record every write, over-long we pulses, err cycles and m_valid cycles.
  int            cyc = 0;
  logic [AW-1:0] wr_addr [$];
  logic [DW-1:0] wr_data [$];
  int            wr_cyc  [$];
  int            we_run = 0;
  int            we_long = 0;
  int            err_cycles = 0;
  int            mvalid_cycles = 0;

  always @(posedge clk) begin
    cyc++;
    if (bus_if.we === 1'b1) begin
      wr_addr.push_back(bus_if.addr);
      wr_data.push_back(bus_if.w_data);
      wr_cyc.push_back(cyc);
      we_run++;
      if (we_run > 1) we_long++;
    end else begin
      we_run = 0;
    end
    if (err === 1'b1) err_cycles++;
    if (m_valid === 1'b1) mvalid_cycles++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_monitor();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    we_long = 0;
    err_cycles = 0;
    mvalid_cycles = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (s_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL send_timeout byte=%02h s_ready=%b required 1", b, s_ready);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f [$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic recv_byte(input bit stall, output logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (m_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (m_valid !== 1'b1) begin
      n_checks++;
      $display("FAIL recv_timeout m_valid=%b required 1", m_valid);
      b = 8'hxx;
      return;
    end
    b = m_data;
    if (stall) begin
      m_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({m_valid, m_data} !== {1'b1, b})
        $display("FAIL stall_hold got valid=%b data=%02h required valid=1 data=%02h", m_valid, m_data, b);
      else
        n_pass++;
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] obs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {s_ready, m_valid, m_data, busy, err, bus_if.addr, bus_if.w_data, bus_if.we};
    n_checks++;
    if (obs !== 35'd0) $display("FAIL reset_values got %h required 0", obs);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s_ready, busy} !== 2'b10) $display("FAIL idle_ready got s_ready=%b busy=%b required 1 0", s_ready, busy);
    else n_pass++;
  endtask

  task automatic test_write_burst();
    logic [7:0] b;
    clear_monitor();
    send_frame('{8'h57, 8'h10, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56});
    recv_byte(1'b0, b);
    n_checks++;
    if (b !== 8'h4B) $display("FAIL wr_ack got %02h required 4B", b); else n_pass++;
    n_checks++;
    if (wr_addr.size() !== 2) $display("FAIL wr_count got %0d required 2", wr_addr.size()); else n_pass++;
    if (wr_addr.size() == 2) begin
      n_checks++;
      if ({wr_addr[0], wr_data[0]} !== {10'h010, 12'h234})
        $display("FAIL wr_word0 got %h@%h required 234@010", wr_data[0], wr_addr[0]);
      else n_pass++;
      n_checks++;
      if ({wr_addr[1], wr_data[1]} !== {10'h011, 12'h678})
        $display("FAIL wr_word1 got %h@%h required 678@011", wr_data[1], wr_addr[1]);
      else n_pass++;
      n_checks++;
      if (wr_cyc[1] - wr_cyc[0] !== 3)
        $display("FAIL wr_throughput got %0d cycles required 3", wr_cyc[1] - wr_cyc[0]);
      else n_pass++;
    end
    n_checks++;
    if (we_long !== 0) $display("FAIL we_width got %0d long pulses required 0", we_long); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL wr_busy_after got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_read_back();
    logic [7:0] exp [5];
    logic [7:0] b;
    exp = '{8'h34, 8'h02, 8'h78, 8'h06, 8'h4B};
    clear_monitor();
    send_frame('{8'h52, 8'h10, 8'h00, 8'h02, 8'h00});
    for (int i = 0; i < 5; i++) begin
      recv_byte(1'b1, b);
      n_checks++;
      if (b !== exp[i]) $display("FAIL rd_byte%0d got %02h required %02h", i, b, exp[i]);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== 0 || m_valid !== 1'b0)
      $display("FAIL rd_no_write got writes=%0d m_valid=%b required 0 0", wr_addr.size(), m_valid);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    logic [7:0] b;
    clear_monitor();
    send_frame('{8'h57, 8'h00, 8'h00, 8'h00, 8'h00});
    recv_byte(1'b0, b);
    n_checks++;
    if (b !== 8'h4B) $display("FAIL zl_ack got %02h required 4B", b); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== 0) $display("FAIL zl_no_write got %0d required 0", wr_addr.size()); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL zl_busy got %b required 0", busy); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    logic [7:0] b;
    clear_monitor();
    send_frame('{8'h57, 8'hFF, 8'h03, 8'h02, 8'h00, 8'hAA, 8'h00, 8'hBB, 8'h00});
    recv_byte(1'b0, b);
    n_checks++;
    if (b !== 8'h4B) $display("FAIL wrap_ack got %02h required 4B", b); else n_pass++;
    n_checks++;
    if (wr_addr.size() !== 2) $display("FAIL wrap_count got %0d required 2", wr_addr.size()); else n_pass++;
    if (wr_addr.size() == 2) begin
      n_checks++;
      if ({wr_addr[0], wr_data[0]} !== {10'h3FF, 12'h0AA})
        $display("FAIL wrap_word0 got %h@%h required 0aa@3ff", wr_data[0], wr_addr[0]);
      else n_pass++;
      n_checks++;
      if ({wr_addr[1], wr_data[1]} !== {10'h000, 12'h0BB})
        $display("FAIL wrap_word1 got %h@%h required 0bb@000", wr_data[1], wr_addr[1]);
      else n_pass++;
    end
  endtask

  task automatic test_bad_opcode();
    logic [7:0] b;
    clear_monitor();
    send_byte(8'hAA);
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_cycles !== 1) $display("FAIL bad_err_width got %0d required 1", err_cycles); else n_pass++;
    n_checks++;
    if (mvalid_cycles !== 0) $display("FAIL bad_no_mvalid got %0d required 0", mvalid_cycles); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL bad_busy got %b required 0", busy); else n_pass++;
    send_frame('{8'h57, 8'h30, 8'h00, 8'h01, 8'h00, 8'hCD, 8'h0B});
    recv_byte(1'b0, b);
    n_checks++;
    if (b !== 8'h4B) $display("FAIL bad_then_ack got %02h required 4B", b); else n_pass++;
    n_checks++;
    if (wr_addr.size() !== 1 || {wr_addr[0], wr_data[0]} !== {10'h030, 12'hBCD})
      $display("FAIL bad_then_write got count=%0d required bcd@030", wr_addr.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    logic [7:0]  b;
    logic [34:0] obs;
    clear_monitor();
    send_frame('{8'h57, 8'h20, 8'h00, 8'h01, 8'h00, 8'h34});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    obs = {s_ready, m_valid, m_data, busy, err, bus_if.addr, bus_if.w_data, bus_if.we};
    n_checks++;
    if (obs !== 35'd0) $display("FAIL mid_reset_values got %h required 0", obs); else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr.size() !== 0) $display("FAIL mid_no_write got %0d required 0", wr_addr.size()); else n_pass++;
    send_frame('{8'h57, 8'h20, 8'h00, 8'h01, 8'h00, 8'h34, 8'h12});
    recv_byte(1'b0, b);
    n_checks++;
    if (b !== 8'h4B) $display("FAIL mid_next_ack got %02h required 4B", b); else n_pass++;
    n_checks++;
    if (wr_addr.size() !== 1 || {wr_addr[0], wr_data[0]} !== {10'h020, 12'h234})
      $display("FAIL mid_next_write got count=%0d required 234@020", wr_addr.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_back();
    test_zero_len();
    test_addr_wrap();
    test_bad_opcode();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
